// File: rtl/video_pkg.sv
// Shared video timing, VRAM geometry and palette definitions for the scanout path.
package video_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int VRAM_W = 128;
  localparam int VRAM_H = 64;
  localparam int PIX_W  = 2;

  // Each VRAM pixel is drawn as a 4x4 block, so the window is 4x the VRAM size.
  localparam int WIN_W  = VRAM_W * 4;
  localparam int WIN_H  = VRAM_H * 4;
  localparam int WIN_X0 = 64;
  localparam int WIN_Y0 = 112;

  localparam logic SYNC_POL = 1'b0;

  typedef logic [11:0] rgb12;

  localparam rgb12 BORDER_RGB = 12'h000;
  localparam rgb12 PAL0 = 12'h000;
  localparam rgb12 PAL1 = 12'h555;
  localparam rgb12 PAL2 = 12'hAAA;
  localparam rgb12 PAL3 = 12'hFFF;

  function automatic rgb12 pal_lookup(input logic [PIX_W-1:0] pix);
    case (pix)
      2'd0:    return PAL0;
      2'd1:    return PAL1;
      2'd2:    return PAL2;
      default: return PAL3;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical pixel counters, stage-0 region flags and the per-frame strobe.
// Counters advance on pix_ce only; frame_start is a single-clk registered pulse.
module vga_timing #(
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int H_FP     = video_pkg::H_FP,
  parameter int H_SYNC   = video_pkg::H_SYNC,
  parameter int H_BP     = video_pkg::H_BP,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int V_FP     = video_pkg::V_FP,
  parameter int V_SYNC   = video_pkg::V_SYNC,
  parameter int V_BP     = video_pkg::V_BP,
  parameter int WIN_X0   = video_pkg::WIN_X0,
  parameter int WIN_Y0   = video_pkg::WIN_Y0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       active,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       win,
  output logic       frame_start
);
  import video_pkg::*;

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] HS0    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] VS0    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] WX0    = 10'(WIN_X0);
  localparam logic [9:0] WX1    = 10'(WIN_X0 + WIN_W);
  localparam logic [9:0] WY0    = 10'(WIN_Y0);
  localparam logic [9:0] WY1    = 10'(WIN_Y0 + WIN_H);

  logic [9:0] h_nxt, v_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    active = (h_cnt < HA) && (v_cnt < VA);
    hs_raw = (h_cnt >= HS0) && (h_cnt < HS1);
    vs_raw = (v_cnt >= VS0) && (v_cnt < VS1);
    win    = (h_cnt >= WX0) && (h_cnt < WX1) && (v_cnt >= WY0) && (v_cnt < WY1);
  end

  // Fires on the enable that consumes position (0,0), including the first one after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) frame_start <= 1'b0;
    else        frame_start <= pix_ce && (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/vram_scanout.sv
// VRAM read-back to 640x480 VGA: 4x-scaled centred window, palette lookup, border colour.
// Counter-to-pin latency is two pix_ce steps for rgb, de, hsync and vsync alike.
module vram_scanout #(
  parameter int          H_ACTIVE   = video_pkg::H_ACTIVE,
  parameter int          H_FP       = video_pkg::H_FP,
  parameter int          H_SYNC     = video_pkg::H_SYNC,
  parameter int          H_BP       = video_pkg::H_BP,
  parameter int          V_ACTIVE   = video_pkg::V_ACTIVE,
  parameter int          V_FP       = video_pkg::V_FP,
  parameter int          V_SYNC     = video_pkg::V_SYNC,
  parameter int          V_BP       = video_pkg::V_BP,
  parameter int          WIN_X0     = video_pkg::WIN_X0,
  parameter int          WIN_Y0     = video_pkg::WIN_Y0,
  parameter logic        SYNC_POL   = video_pkg::SYNC_POL,
  parameter logic [11:0] BORDER_RGB = video_pkg::BORDER_RGB
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  output logic [6:0]  vram_hpos,
  output logic [5:0]  vram_vpos,
  input  logic [1:0]  vram_pixelo,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] rgb,
  output logic        frame_start
);
  import video_pkg::*;

  localparam int HPOS_W = $clog2(VRAM_W);
  localparam int VPOS_W = $clog2(VRAM_H);
  localparam logic [9:0] WX0 = 10'(WIN_X0);
  localparam logic [9:0] WY0 = 10'(WIN_Y0);

  logic [9:0] h_cnt, v_cnt;
  logic       act0, hs0, vs0, win0;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0)
  ) u_timing (
    .clk(clk),
    .rst_n(rst_n),
    .pix_ce(pix_ce),
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .active(act0),
    .hs_raw(hs0),
    .vs_raw(vs0),
    .win(win0),
    .frame_start(frame_start)
  );

  // Dividing the window offset by 4 undoes the 4x4 pixel scaling.
  assign vram_hpos = win0 ? HPOS_W'((h_cnt - WX0) >> 2) : '0;
  assign vram_vpos = win0 ? VPOS_W'((v_cnt - WY0) >> 2) : '0;

  // Read data lands one clk after the address moves; with a slow pix_ce it must be
  // caught then, since the address has already advanced when the next enable arrives.
  logic       ce_d;
  logic [1:0] pix_q, pix_cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ce_d  <= 1'b0;
      pix_q <= '0;
    end else begin
      ce_d <= pix_ce;
      if (ce_d) pix_q <= vram_pixelo;
    end
  end

  assign pix_cur = ce_d ? vram_pixelo : pix_q;

  logic s1_act, s1_hs, s1_vs, s1_win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_act <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_win <= 1'b0;
      de     <= 1'b0;
      hsync  <= ~SYNC_POL;
      vsync  <= ~SYNC_POL;
      rgb    <= '0;
    end else if (pix_ce) begin
      s1_act <= act0;
      s1_hs  <= hs0;
      s1_vs  <= vs0;
      s1_win <= win0;
      de     <= s1_act;
      hsync  <= ~(s1_hs ^ SYNC_POL);
      vsync  <= ~(s1_vs ^ SYNC_POL);
      if (!s1_act)     rgb <= '0;
      else if (s1_win) rgb <= pal_lookup(pix_cur);
      else             rgb <= BORDER_RGB;
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Directed bench for vram_scanout; vertical timing is shortened (18-line frame, window
// starting on line 1) so whole frames fit in a short run. Horizontal timing is standard.
module tb_vram_scanout;

  localparam int HT = 800;
  localparam int VT = 18;
  localparam int FRAME = HT * VT;
  localparam int NREF = 1700;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_ce = 1'b0;
  logic [6:0]  vram_hpos;
  logic [5:0]  vram_vpos;
  logic [1:0]  vram_pixelo;
  logic        hsync, vsync, de, frame_start;
  logic [11:0] rgb;
  wire  [14:0] cur_out = {hsync, vsync, de, rgb};

  int     n_checks = 0;
  int     n_fail = 0;
  int     mode = 0;
  longint cyc = 0;
  logic [14:0] ref_out [1:NREF];

  vram_scanout #(
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2), .WIN_Y0(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_ce(pix_ce),
    .vram_hpos(vram_hpos),
    .vram_vpos(vram_vpos),
    .vram_pixelo(vram_pixelo),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .rgb(rgb),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: only VRAM (0,0) holds 3; mode 1: pixel value = column[1:0]
  function automatic int pix_at(input int col, input int row);
    if (mode == 0) return (col == 0 && row == 0) ? 3 : 0;
    return col % 4;
  endfunction

  always @(posedge clk) vram_pixelo <= 2'(pix_at(int'(vram_hpos), int'(vram_vpos)));

  function automatic logic [11:0] pal(input int p);
    case (p)
      0:       return 12'h000;
      1:       return 12'h555;
      2:       return 12'hAAA;
      default: return 12'hFFF;
    endcase
  endfunction

  // Expected {hsync, vsync, de, rgb} for counter position q (pins show q two steps later).
  function automatic logic [14:0] exp_out(input int q);
    int p, h, v;
    logic de_e, hs_e, vs_e, win_e;
    logic [11:0] c;
    p = q;
    if (p < 0) p = p + FRAME;
    p = p % FRAME;
    h = p % HT;
    v = p / HT;
    de_e  = (h < 640) && (v < 12);
    hs_e  = !((h >= 656) && (h < 752));
    vs_e  = !((v >= 14) && (v < 16));
    win_e = (h >= 64) && (h < 576) && (v >= 1) && (v < 257);
    c = 12'h000;
    if (de_e && win_e) c = pal(pix_at((h - 64) / 4, (v - 1) / 4));
    return {hs_e, vs_e, de_e, c};
  endfunction

  function automatic logic [12:0] exp_addr(input int p);
    int h, v;
    h = (p % FRAME) % HT;
    v = (p % FRAME) / HT;
    if ((h >= 64) && (h < 576) && (v >= 1) && (v < 257))
      return {7'((h - 64) / 4), 6'((v - 1) / 4)};
    return 13'd0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    pix_ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pix_ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({hsync, vsync, de, rgb, frame_start} !== {1'b1, 1'b1, 1'b0, 12'h000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: hs/vs/de/rgb/fs got %b/%b/%b/%h/%b expected 1/1/0/000/0",
               hsync, vsync, de, rgb, frame_start);
    end
    n_checks++;
    if ({vram_hpos, vram_vpos} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %0d,%0d expected 0,0", vram_hpos, vram_vpos);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_timing();
    int hs_line, vs_tot, mism_wave, mism_addr, fs_cnt;
    longint fs_first, fs_second;
    hs_line = 0; vs_tot = 0; mism_wave = 0; mism_addr = 0; fs_cnt = 0;
    fs_first = 0; fs_second = 0;
    mode = 1;
    do_reset();
    for (int n = 1; n <= FRAME; n++) begin
      @(posedge clk); #1;
      if (n <= NREF) ref_out[n] = cur_out;
      if (!hsync) hs_line++;
      if (!vsync) vs_tot++;
      if (cur_out !== exp_out(n - 2)) mism_wave++;
      if ({vram_hpos, vram_vpos} !== exp_addr(n)) mism_addr++;
      if (frame_start) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_first = cyc;
      end
      if (n == 1) begin
        n_checks++;
        if (frame_start !== 1'b1) begin
          n_fail++; $display("FAIL fs_first_step: got %b expected 1", frame_start);
        end
      end
      if (n == 2) begin
        n_checks++;
        if (frame_start !== 1'b0) begin
          n_fail++; $display("FAIL fs_width: got %b expected 0", frame_start);
        end
      end
      if (n == HT + 575) begin
        n_checks++;
        if ({vram_hpos, vram_vpos} !== {7'd127, 6'd0}) begin
          n_fail++; $display("FAIL addr_last_col: got %0d,%0d expected 127,0", vram_hpos, vram_vpos);
        end
      end
      if (n == 16 * HT + 64) begin
        n_checks++;
        if ({vram_hpos, vram_vpos} !== {7'd0, 6'd3}) begin
          n_fail++; $display("FAIL addr_row: got %0d,%0d expected 0,3", vram_hpos, vram_vpos);
        end
      end
      if (n % HT == 0) begin
        n_checks++;
        if (hs_line != 96) begin
          n_fail++; $display("FAIL hsync_width line %0d: got %0d clks expected 96", n / HT - 1, hs_line);
        end
        hs_line = 0;
      end
    end
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (frame_start && fs_second == 0) fs_second = cyc;
    end
    n_checks++;
    if (vs_tot != 2 * HT) begin
      n_fail++; $display("FAIL vsync_width: got %0d clks expected %0d", vs_tot, 2 * HT);
    end
    n_checks++;
    if (fs_cnt != 1) begin
      n_fail++; $display("FAIL fs_per_frame: got %0d expected 1", fs_cnt);
    end
    n_checks++;
    if (fs_second - fs_first != longint'(FRAME)) begin
      n_fail++; $display("FAIL fs_period: got %0d expected %0d", fs_second - fs_first, FRAME);
    end
    n_checks++;
    if (mism_wave != 0) begin
      n_fail++; $display("FAIL frame_waveform: got %0d bad steps expected 0", mism_wave);
    end
    n_checks++;
    if (mism_addr != 0) begin
      n_fail++; $display("FAIL frame_addr: got %0d bad steps expected 0", mism_addr);
    end
  endtask

  task automatic test_ce_div();
    int mism_step, mism_hold, fs_extra;
    logic [14:0] snap;
    mism_step = 0; mism_hold = 0; fs_extra = 0;
    mode = 1;
    do_reset();
    for (int n = 1; n <= NREF; n++) begin
      pix_ce = 1'b1;
      @(posedge clk); #1;
      pix_ce = 1'b0;
      snap = cur_out;
      if (snap !== ref_out[n]) mism_step++;
      if (n == 1) begin
        n_checks++;
        if (frame_start !== 1'b1) begin
          n_fail++; $display("FAIL ce4_fs: got %b expected 1", frame_start);
        end
      end
      repeat (3) begin
        @(posedge clk); #1;
        if (cur_out !== snap) mism_hold++;
        if (frame_start) fs_extra++;
      end
    end
    pix_ce = 1'b1;
    n_checks++;
    if (mism_step != 0) begin
      n_fail++; $display("FAIL ce4_vs_full_rate: got %0d bad steps expected 0", mism_step);
    end
    n_checks++;
    if (mism_hold != 0) begin
      n_fail++; $display("FAIL ce4_hold: got %0d changes expected 0", mism_hold);
    end
    n_checks++;
    if (fs_extra != 0) begin
      n_fail++; $display("FAIL ce4_fs_width: got %0d extra clks expected 0", fs_extra);
    end
  endtask

  task automatic test_window();
    int q, h, v;
    mode = 0;
    do_reset();
    for (int n = 1; n <= 6 * HT; n++) begin
      @(posedge clk); #1;
      q = n - 2;
      if (q >= 0) begin
        h = q % HT;
        v = q / HT;
        if ((h == 64 || h == 67) && (v == 1 || v == 4)) begin
          n_checks++;
          if (rgb !== 12'hFFF || de !== 1'b1) begin
            n_fail++; $display("FAIL win_pixel00 h=%0d v=%0d: got rgb %h de %b expected FFF 1", h, v, rgb, de);
          end
        end
        if ((h == 68 && v == 1) || (h == 63 && v == 1) || (h == 64 && v == 5) || (h == 64 && v == 0)) begin
          n_checks++;
          if (rgb !== 12'h000 || de !== 1'b1) begin
            n_fail++; $display("FAIL win_dark h=%0d v=%0d: got rgb %h de %b expected 000 1", h, v, rgb, de);
          end
        end
      end
    end
  endtask

  task automatic test_pattern();
    int hp [10];
    logic [11:0] ex [10];
    int q, h, v;
    hp = '{0, 63, 64, 68, 72, 76, 80, 575, 576, 639};
    ex = '{12'h000, 12'h000, 12'h000, 12'h555, 12'hAAA, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000};
    mode = 1;
    do_reset();
    for (int n = 1; n <= 2 * HT + 2; n++) begin
      @(posedge clk); #1;
      q = n - 2;
      h = q % HT;
      v = q / HT;
      if (q >= 0 && v == 1) begin
        for (int k = 0; k < 10; k++) begin
          if (h == hp[k]) begin
            n_checks++;
            if (rgb !== ex[k] || de !== 1'b1) begin
              n_fail++; $display("FAIL pattern h=%0d: got rgb %h de %b expected %h 1", h, rgb, de, ex[k]);
            end
          end
        end
        if (h == 640) begin
          n_checks++;
          if (rgb !== 12'h000 || de !== 1'b0) begin
            n_fail++; $display("FAIL pattern_blank: got rgb %h de %b expected 000 0", rgb, de);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    mode = 1;
    do_reset();
    for (int n = 1; n <= 10 * HT + 300; n++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({hsync, vsync, de, rgb} !== {1'b1, 1'b1, 1'b0, 12'h000}) begin
      n_fail++; $display("FAIL mid_reset_clear: got hs/vs/de/rgb %b/%b/%b/%h expected 1/1/0/000", hsync, vsync, de, rgb);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({hsync, vsync, de, frame_start} !== 4'b1101) begin
      n_fail++; $display("FAIL post_reset_step1: got hs/vs/de/fs %b%b%b%b expected 1101", hsync, vsync, de, frame_start);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({de, frame_start} !== 2'b10) begin
      n_fail++; $display("FAIL post_reset_step2: got de/fs %b%b expected 10", de, frame_start);
    end
    for (int n = 3; n <= HT + 68; n++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if ({vram_hpos, vram_vpos} !== {7'd1, 6'd0}) begin
      n_fail++; $display("FAIL post_reset_addr: got %0d,%0d expected 1,0", vram_hpos, vram_vpos);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_ce_div();
    test_window();
    test_pattern();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
